// File: rtl/decode.sv
// decode: RV32I decode stage with register file, load-use stall and flush.
// Define DECODE_WB_BYPASS_EN to forward the writeback port to same-cycle reads.
`ifndef WORD
`define WORD 32
`endif

module decode #(
  parameter int WIDTH = `WORD,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pcD,
  input  logic [WIDTH-1:0] instrD,
  input  logic             wbenW,
  input  logic [4:0]       wbaddrW,
  input  logic [WIDTH-1:0] wbdataW,
  input  logic             flushD,
  output logic             stallF,
  output logic [WIDTH-1:0] pcE,
  output logic [WIDTH-1:0] rs1valE,
  output logic [WIDTH-1:0] rs2valE,
  output logic [WIDTH-1:0] immE,
  output logic [4:0]       rs1E,
  output logic [4:0]       rs2E,
  output logic [4:0]       rdE,
  output logic [2:0]       funct3E,
  output logic             f7bE,
  output logic [3:0]       opclassE,
  output logic             validE,
  output logic             regwrE,
  output logic             memrdE
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] OC_OP     = 4'd0;
  localparam logic [3:0] OC_OPIMM  = 4'd1;
  localparam logic [3:0] OC_LOAD   = 4'd2;
  localparam logic [3:0] OC_STORE  = 4'd3;
  localparam logic [3:0] OC_BRANCH = 4'd4;
  localparam logic [3:0] OC_JAL    = 4'd5;
  localparam logic [3:0] OC_JALR   = 4'd6;
  localparam logic [3:0] OC_LUI    = 4'd7;
  localparam logic [3:0] OC_AUIPC  = 4'd8;
  localparam logic [3:0] OC_SYSTEM = 4'd9;
  localparam logic [3:0] OC_ILL    = 4'd15;

  typedef struct packed {
    logic             valid;
    logic             regwr;
    logic             memrd;
    logic [3:0]       cls;
    logic [2:0]       f3;
    logic             f7b;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rs1v;
    logic [WIDTH-1:0] rs2v;
    logic [WIDTH-1:0] imm;
  } e_t;

  logic [6:0]       opc;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic             i31;
  logic [3:0]       cls;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] imm_i;
  logic [WIDTH-1:0] imm_s;
  logic [WIDTH-1:0] imm_b;
  logic [WIDTH-1:0] imm_u;
  logic [WIDTH-1:0] imm_j;
  logic             wr_cls;
  logic             rs1_used;
  logic             rs2_used;
  logic             load_use;
  logic             rf_we;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic [WIDTH-1:0] rf_q [NREGS];
  e_t               e_d;
  e_t               e_q;

  assign opc = instrD[6:0];
  assign rd  = instrD[11:7];
  assign rs1 = instrD[19:15];
  assign rs2 = instrD[24:20];
  assign i31 = instrD[31];

  always_comb begin
    cls = OC_ILL;
    unique case (1'b1)
      (opc == OPC_OP):     cls = OC_OP;
      (opc == OPC_OPIMM):  cls = OC_OPIMM;
      (opc == OPC_LOAD):   cls = OC_LOAD;
      (opc == OPC_STORE):  cls = OC_STORE;
      (opc == OPC_BRANCH): cls = OC_BRANCH;
      (opc == OPC_JAL):    cls = OC_JAL;
      (opc == OPC_JALR):   cls = OC_JALR;
      (opc == OPC_LUI):    cls = OC_LUI;
      (opc == OPC_AUIPC):  cls = OC_AUIPC;
      (opc == OPC_SYSTEM): cls = OC_SYSTEM;
      default:             cls = OC_ILL;
    endcase
  end

  assign imm_i = {{(WIDTH-11){i31}}, instrD[30:20]};
  assign imm_s = {{(WIDTH-11){i31}}, instrD[30:25], instrD[11:7]};
  assign imm_b = {{(WIDTH-12){i31}}, instrD[7], instrD[30:25],
                  instrD[11:8], 1'b0};
  assign imm_u = {{(WIDTH-31){i31}}, instrD[30:12], 12'b0};
  assign imm_j = {{(WIDTH-20){i31}}, instrD[19:12], instrD[20],
                  instrD[30:21], 1'b0};

  always_comb begin
    imm = '0;
    unique case (1'b1)
      (cls == OC_OPIMM),
      (cls == OC_LOAD),
      (cls == OC_JALR):   imm = imm_i;
      (cls == OC_STORE):  imm = imm_s;
      (cls == OC_BRANCH): imm = imm_b;
      (cls == OC_LUI),
      (cls == OC_AUIPC):  imm = imm_u;
      (cls == OC_JAL):    imm = imm_j;
      default:            imm = '0;
    endcase
  end

  assign wr_cls = (cls == OC_OP) || (cls == OC_OPIMM) ||
                  (cls == OC_LOAD) || (cls == OC_JAL) ||
                  (cls == OC_JALR) || (cls == OC_LUI) ||
                  (cls == OC_AUIPC);

  assign rs1_used = !((cls == OC_LUI) || (cls == OC_AUIPC) ||
                      (cls == OC_JAL));
  assign rs2_used = (cls == OC_OP) || (cls == OC_STORE) ||
                    (cls == OC_BRANCH);

  assign rf_we = wbenW && (wbaddrW != 5'd0) &&
                 (32'(wbaddrW) < 32'(NREGS));

  // x0 has no storage: entry 0 is never written and reads are forced to 0
  always_ff @(posedge clk) begin
    if (rf_we) rf_q[wbaddrW] <= wbdataW;
  end

  always_comb begin
    rs1_val = '0;
    if (rs1 != 5'd0 && 32'(rs1) < 32'(NREGS)) rs1_val = rf_q[rs1];
`ifdef DECODE_WB_BYPASS_EN
    if (rf_we && wbaddrW == rs1) rs1_val = wbdataW;
`endif
  end

  always_comb begin
    rs2_val = '0;
    if (rs2 != 5'd0 && 32'(rs2) < 32'(NREGS)) rs2_val = rf_q[rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (rf_we && wbaddrW == rs2) rs2_val = wbdataW;
`endif
  end

  assign load_use = e_q.valid && e_q.memrd && (e_q.rd != 5'd0) &&
                    ((e_q.rd == rs1 && rs1_used) ||
                     (e_q.rd == rs2 && rs2_used));

  // a flush already discards this instruction, so it never needs to stall
  assign stallF = !flushD && load_use;

  always_comb begin
    e_d = '0;
    if (!flushD && !load_use) begin
      e_d.valid = 1'b1;
      e_d.regwr = wr_cls && (rd != 5'd0);
      e_d.memrd = (cls == OC_LOAD);
      e_d.cls   = cls;
      e_d.f3    = instrD[14:12];
      e_d.f7b   = instrD[30];
      e_d.rs1   = rs1;
      e_d.rs2   = rs2;
      e_d.rd    = rd;
      e_d.pc    = pcD;
      e_d.rs1v  = rs1_val;
      e_d.rs2v  = rs2_val;
      e_d.imm   = imm;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) e_q <= '0;
    else        e_q <= e_d;
  end

  assign validE   = e_q.valid;
  assign regwrE   = e_q.regwr;
  assign memrdE   = e_q.memrd;
  assign opclassE = e_q.cls;
  assign funct3E  = e_q.f3;
  assign f7bE     = e_q.f7b;
  assign rs1E     = e_q.rs1;
  assign rs2E     = e_q.rs2;
  assign rdE      = e_q.rd;
  assign pcE      = e_q.pc;
  assign rs1valE  = e_q.rs1v;
  assign rs2valE  = e_q.rs2v;
  assign immE     = e_q.imm;

endmodule
